uart_mmio_responder: RTL

Memory-mapped UART peripheral that answers the single-cycle core's data-memory load/store accesses. It sits beside `Memory` on the `ALUResult`/`WriteData`/`ReadData` path, selected by the top-level address decoder. It serialises bytes written by the core onto `tx` and deserialises frames from `rx` into a FIFO the core reads. Format is 8N1, LSB first, fixed baud.

---
 rtl/uart_mmio_responder_pkg.sv | 16 +
 rtl/uart_mmio_responder_if.sv | 11 +
 rtl/uart_sync_fifo.sv | 37 +++
 rtl/uart_mmio_responder.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/uart_mmio_responder_pkg.sv
// uart_mmio_responder_pkg: register offsets, STATUS bit indices and FSM encodings for the MMIO UART
package uart_mmio_responder_pkg;
  localparam logic [1:0] UART_TXDATA = 2'd0;
  localparam logic [1:0] UART_RXDATA = 2'd1;
  localparam logic [1:0] UART_STATUS = 2'd2;
  localparam logic [1:0] UART_CTRL   = 2'd3;
  localparam int ST_TX_FULL     = 0;
  localparam int ST_TX_IDLE     = 1;
  localparam int ST_RX_VALID    = 2;
  localparam int ST_RX_FULL     = 3;
  localparam int ST_RX_OVERRUN  = 4;
  localparam int ST_FRAME_ERR   = 5;
  localparam int ST_TX_OVERFLOW = 6;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
endpackage

// File: rtl/uart_mmio_responder_if.sv
// uart_mmio_responder_if: core load/store bus (sel, WE, RE, ADDR, WD in; RD out) with master/slave modports
interface uart_mmio_responder_if;
  logic        sel;
  logic [1:0]  WE;
  logic        RE;
  logic [31:0] ADDR;
  logic [31:0] WD;
  logic [31:0] RD;
  modport master (output sel, WE, RE, ADDR, WD, input RD);
  modport slave (input sel, WE, RE, ADDR, WD, output RD);
endinterface

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: 8-bit first-word-fall-through FIFO (clk, rst, push/din, pop/head, full, empty); push while full is taken if a pop coincides
module uart_sync_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] head,
  output logic       full,
  output logic       empty
);
  localparam int AW = $clog2(DEPTH);
  logic [7:0] mem_q [DEPTH];
  logic [AW:0] wr_q, wr_d, rd_q, rd_d;
  logic do_push, do_pop;
  always_comb begin
    empty = wr_q == rd_q;
    full = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    do_pop = pop & ~empty;
    do_push = push & (~full | do_pop);
    wr_d = wr_q + {{AW{1'b0}}, do_push};
    rd_d = rd_q + {{AW{1'b0}}, do_pop};
    head = mem_q[rd_q[AW-1:0]];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
    if (do_push) mem_q[wr_q[AW-1:0]] <= din;
  end
endmodule

// File: rtl/uart_mmio_responder.sv
// uart_mmio_responder: 8N1 MMIO UART (clk, reset, bus slave for TXDATA/RXDATA/STATUS/CTRL, tx out, rx in, rx_irq out)
module uart_mmio_responder
  import uart_mmio_responder_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  uart_mmio_responder_if.slave bus,
  output logic                 tx,
  input  logic                 rx,
  output logic                 rx_irq
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  logic [1:0] addr;
  logic wr, rd;
  logic tx_push, tx_pop, tx_full, tx_empty;
  logic rx_push, rx_pop, rx_full, rx_empty, rx_ferr;
  logic [7:0] tx_head, rx_head;
  logic [2:0] sticky_q, sticky_d, sticky_clr;
  logic [31:0] status;
  tx_state_t tx_st_q, tx_st_d;
  rx_state_t rx_st_q, rx_st_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
  logic [2:0] tx_bit_q, tx_bit_d, rx_bit_q, rx_bit_d;
  logic [7:0] tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d;
  logic tx_q, tx_d;
  logic [1:0] sync_q, sync_d;
  logic rx_s, tx_tick, rx_tick;
  logic unused;
  assign unused = ^{bus.ADDR[31:4], bus.ADDR[1:0], bus.WD[31:8]};
  uart_sync_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk), .rst(reset), .push(tx_push), .pop(tx_pop), .din(bus.WD[7:0]),
    .head(tx_head), .full(tx_full), .empty(tx_empty)
  );
  uart_sync_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .rst(reset), .push(rx_push), .pop(rx_pop), .din(rx_sh_q),
    .head(rx_head), .full(rx_full), .empty(rx_empty)
  );
  always_comb begin
    addr = bus.ADDR[3:2];
    wr = bus.sel & |bus.WE;
    rd = bus.sel & bus.RE;
    tx_push = wr & (addr == UART_TXDATA);
    rx_pop = rd & (addr == UART_RXDATA);
    sticky_clr = (wr & (addr == UART_CTRL)) ? bus.WD[6:4] : 3'b0;
    status = '0;
    status[ST_TX_FULL] = tx_full;
    status[ST_TX_IDLE] = tx_empty & (tx_st_q == TX_IDLE);
    status[ST_RX_VALID] = ~rx_empty;
    status[ST_RX_FULL] = rx_full;
    status[ST_RX_OVERRUN] = sticky_q[0];
    status[ST_FRAME_ERR] = sticky_q[1];
    status[ST_TX_OVERFLOW] = sticky_q[2];
    bus.RD = !bus.sel ? '0 :
             (addr == UART_RXDATA) ? {24'b0, rx_empty ? 8'h00 : rx_head} :
             (addr == UART_STATUS) ? status : '0;
  end
  // set wins over a same-cycle W1C clear
  always_comb begin
    sticky_d = (sticky_q & ~sticky_clr) |
               {tx_push & tx_full & ~tx_pop, rx_ferr, rx_push & rx_full & ~rx_pop};
  end
  always_comb begin
    tx_tick = tx_cnt_q == '0;
    tx_st_d = tx_st_q;
    tx_cnt_d = tx_tick ? FULL : tx_cnt_q - CW'(1);
    tx_bit_d = tx_bit_q;
    tx_sh_d = tx_sh_q;
    tx_d = tx_q;
    tx_pop = 1'b0;
    case (tx_st_q)
      TX_IDLE: begin
        tx_cnt_d = FULL;
        if (!tx_empty) begin
          tx_pop = 1'b1;
          tx_st_d = TX_START;
          tx_sh_d = tx_head;
          tx_d = 1'b0;
        end
      end
      TX_START: if (tx_tick) begin
        tx_st_d = TX_DATA;
        tx_bit_d = 3'd0;
        tx_d = tx_sh_q[0];
      end
      TX_DATA: if (tx_tick) begin
        if (tx_bit_q == 3'd7) begin
          tx_st_d = TX_STOP;
          tx_d = 1'b1;
        end else begin
          tx_bit_d = tx_bit_q + 3'd1;
          tx_sh_d = tx_sh_q >> 1;
          tx_d = tx_sh_q[1];
        end
      end
      TX_STOP: if (tx_tick) begin
        if (!tx_empty) begin
          tx_pop = 1'b1;
          tx_st_d = TX_START;
          tx_sh_d = tx_head;
          tx_d = 1'b0;
        end else begin
          tx_st_d = TX_IDLE;
        end
      end
    endcase
  end
  always_comb begin
    sync_d = {sync_q[0], rx};
    rx_s = sync_q[1];
    rx_tick = rx_cnt_q == '0;
    rx_st_d = rx_st_q;
    rx_cnt_d = rx_tick ? FULL : rx_cnt_q - CW'(1);
    rx_bit_d = rx_bit_q;
    rx_sh_d = rx_sh_q;
    rx_push = (rx_st_q == RX_STOP) & rx_tick & rx_s;
    rx_ferr = (rx_st_q == RX_STOP) & rx_tick & ~rx_s;
    case (rx_st_q)
      RX_IDLE: begin
        rx_cnt_d = HALF;
        if (!rx_s) rx_st_d = RX_START;
      end
      // resample mid start bit so short low glitches fall back to idle
      RX_START: if (rx_tick) begin
        rx_st_d = rx_s ? RX_IDLE : RX_DATA;
        rx_bit_d = 3'd0;
      end
      RX_DATA: if (rx_tick) begin
        rx_sh_d = {rx_s, rx_sh_q[7:1]};
        rx_bit_d = rx_bit_q + 3'd1;
        if (rx_bit_q == 3'd7) rx_st_d = RX_STOP;
      end
      RX_STOP: if (rx_tick) rx_st_d = RX_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_st_q <= TX_IDLE;
      rx_st_q <= RX_IDLE;
      tx_cnt_q <= '0;
      rx_cnt_q <= '0;
      tx_bit_q <= '0;
      rx_bit_q <= '0;
      tx_sh_q <= '0;
      rx_sh_q <= '0;
      tx_q <= 1'b1;
      sync_q <= 2'b11;
      sticky_q <= '0;
    end else begin
      tx_st_q <= tx_st_d;
      rx_st_q <= rx_st_d;
      tx_cnt_q <= tx_cnt_d;
      rx_cnt_q <= rx_cnt_d;
      tx_bit_q <= tx_bit_d;
      rx_bit_q <= rx_bit_d;
      tx_sh_q <= tx_sh_d;
      rx_sh_q <= rx_sh_d;
      tx_q <= tx_d;
      sync_q <= sync_d;
      sticky_q <= sticky_d;
    end
  end
  assign tx = tx_q;
  assign rx_irq = ~rx_empty;
endmodule
